serial_sub: RTL and testbench

SERIAL_SUB -- requirements
Module: serial_sub

---
 rtl/serial_sub.sv | 86 ++++++++
 tb/tb_serial_sub.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: computes A - B - Bin one bit per clock, LSB first.
// Diff/Bout are registered and only update when an operation completes.
//
// state  | meaning
// S_IDLE | waiting for start; last result held
// S_CALC | shifting one bit per cycle; busy high
// S_DONE | result just landed; done high for this cycle only
module serial_sub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] pd;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             d;
    logic             br_next;

    assign d       = a_sr[0] ^ b_sr[0] ^ br;
    assign br_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);

    assign busy = (state == S_CALC);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            pd    <= '0;
            cnt   <= '0;
            br    <= 1'b0;
            Diff  <= '0;
            Bout  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_sr  <= A;
                        b_sr  <= B;
                        br    <= Bin;
                        cnt   <= '0;
                        state <= S_CALC;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    pd   <= {d, pd[WIDTH-1:1]};
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    br   <= br_next;
                    cnt  <= cnt + CW'(1);
                    // the final bit goes straight into Diff so no partial value is ever visible
                    if (cnt == LAST) begin
                        Diff  <= {d, pd[WIDTH-1:1]};
                        Bout  <= br_next;
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub (WIDTH=4): known vectors, start-during-CALC,
// back-to-back via DONE, mid-operation reset, and an exhaustive A/B/Bin sweep.
module tb_serial_sub;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic       Bin;
    logic [3:0] Diff;
    logic       Bout;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    serial_sub #(.WIDTH(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .A    (A),
        .B    (B),
        .Bin  (Bin),
        .Diff (Diff),
        .Bout (Bout),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Waits (bounded) at negedges for done; returns how many busy cycles were seen first.
    task automatic wait_done(output int nbusy, output bit seen);
        nbusy = 0;
        seen  = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done) seen = 1;
            else begin
                if (busy) nbusy++;
                @(negedge clk);
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic bi, input logic [3:0] ed, input logic eb);
        int nb;
        bit seen;
        @(negedge clk);
        A = a; B = b; Bin = bi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = 4'($urandom); B = 4'($urandom); Bin = 1'($urandom);
        wait_done(nb, seen);
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        check({tag, " busy_cycles"}, 32'(nb), 32'd4);
        check({tag, " diff"}, 32'(Diff), 32'(ed));
        check({tag, " bout"}, 32'(Bout), 32'(eb));
        @(negedge clk);
        check({tag, " done_one_cycle"}, 32'(done), 32'd0);
        check({tag, " idle_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int nb;
        int ndone;
        bit seen;
        logic [4:0] exp5;

        rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset diff", 32'(Diff), 32'd0);
        check("reset bout", 32'(Bout), 32'd0);
        rst_n = 1'b1;

        run_op("5-3-0", 4'd5, 4'd3, 1'b0, 4'd2, 1'b0);
        run_op("3-5-0", 4'd3, 4'd5, 1'b0, 4'd14, 1'b1);
        run_op("0-0-1", 4'd0, 4'd0, 1'b1, 4'd15, 1'b1);
        run_op("15-15-0", 4'd15, 4'd15, 1'b0, 4'd0, 1'b0);

        // start re-asserted during CALC must be ignored
        @(negedge clk);
        A = 4'd7; B = 4'd2; Bin = 1'b0; start = 1'b1;
        @(negedge clk);
        A = 4'd9; B = 4'd1;
        check("ignore busy", 32'(busy), 32'd1);
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_done(nb, seen);
        check("ignore done_seen", 32'(seen), 32'd1);
        check("ignore diff", 32'(Diff), 32'd5);
        check("ignore bout", 32'(Bout), 32'd0);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("ignore single_done", 32'(ndone), 32'd1);

        // back-to-back: start held through DONE
        A = 4'd8; B = 4'd8; Bin = 1'b0; start = 1'b1;
        @(negedge clk);
        wait_done(nb, seen);
        check("b2b first done_seen", 32'(seen), 32'd1);
        check("b2b first diff", 32'(Diff), 32'd0);
        check("b2b first bout", 32'(Bout), 32'd0);
        A = 4'd1; B = 4'd2;
        @(negedge clk);
        start = 1'b0;
        check("b2b no idle gap", 32'(busy), 32'd1);
        check("b2b held diff", 32'(Diff), 32'd0);
        wait_done(nb, seen);
        check("b2b second done_seen", 32'(seen), 32'd1);
        check("b2b second diff", 32'(Diff), 32'd15);
        check("b2b second bout", 32'(Bout), 32'd1);
        @(negedge clk);

        // reset during the second CALC cycle aborts cleanly
        A = 4'd5; B = 4'd3; Bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort diff", 32'(Diff), 32'd0);
        check("abort bout", 32'(Bout), 32'd0);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) ndone++;
            @(negedge clk);
        end
        check("abort no_done", 32'(ndone), 32'd0);
        run_op("after abort 6-4-1", 4'd6, 4'd4, 1'b1, 4'd1, 1'b0);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int bi = 0; bi < 2; bi++) begin
                    exp5 = 5'(a + 32 - b - bi);
                    run_op($sformatf("sweep %0d-%0d-%0d", a, b, bi), 4'(a), 4'(b), 1'(bi),
                           exp5[3:0], exp5[4]);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
